fetch_issue_stage: RTL and testbench
====================================

// Module: fetch_issue_stage
// PURPOSE
// Sits between the per-warp independent-thread-scheduling units and the instruction cache.
// - Picks one ready (warp, subwarp) per cycle with round-robin arbitration across warps.
// - Issues its PC to the instruction cache and tracks in-flight fetches in order.
// - Pairs each returned instruction with its PC, active mask, warp id and subwarp id.
// - Hands the result to the decoder over a valid/ready handshake.
// PARAMETERS
// NumWarps        8   number of warps (one ITS unit each)
// WarpWidth       32  threads per warp; active-mask width
// PcWidth         32  program counter width
// InstrWidth      32  instruction word width
// MaxOutstanding  4   max fetches issued but not yet accepted by the decoder; power of 2, >=2
// PORTS
// clk_i              in   1                        clock
// rst_ni             in   1                        async reset, active low
// warp_ready_i       in   NumWarps                 ITS unit has a fetchable PC (ready_for_fetch_o)
// warp_pc_i          in   NumWarps*PcWidth         per-warp fetch PC
// warp_act_mask_i    in   NumWarps*WarpWidth       per-warp active mask
// warp_subwarp_id_i  in   NumWarps*clog2(WarpWidth) per-warp subwarp id
// warp_selected_o    out  NumWarps                 one-hot grant; drives ITS selected_for_fetch_i
// ic_req_valid_o     out  1                        fetch request valid
// ic_req_ready_i     in   1                        cache accepts request
// ic_req_pc_o        out  PcWidth                  fetch address
// ic_req_tag_o       out  clog2(NumWarps)          warp id of request
// ic_rsp_valid_i     in   1                        response valid; no backpressure possible
// ic_rsp_tag_i       in   clog2(NumWarps)          warp id of response
// ic_rsp_instr_i     in   InstrWidth               fetched instruction
// dec_valid_o        out  1                        instruction available for decoder
// dec_ready_i        in   1                        decoder accepts
// dec_pc_o / dec_act_mask_o / dec_warp_id_o / dec_subwarp_id_o / dec_instr_o  out  (per type)  decoded-stage payload
// BEHAVIOUR
// - Reset values: warp_selected_o=0, ic_req_valid_o=0, dec_valid_o=0, RR pointer=0, both FIFOs empty.
// - Issue is combinational.
//   - ic_req_valid_o = |warp_ready_i && !meta_full.
//   - Winner = first ready warp at or after the RR pointer (wrapping).
//   - ic_req_pc_o and ic_req_tag_o come from the winner.
// - warp_selected_o[w] = 1 only in the cycle ic_req_valid_o && ic_req_ready_i with w the winner.
//   - It is never asserted without the handshake.
//   - On handshake the RR pointer becomes (w+1) mod NumWarps.
//   - Without a handshake the winner is not locked; it may change.
// - meta FIFO, depth MaxOutstanding, holds {pc, act_mask, warp_id, subwarp_id}.
//   - Push on request handshake; pop on decoder handshake.
//   - Its occupancy therefore counts outstanding plus buffered entries.
// - instr FIFO, depth MaxOutstanding, holds instructions.
//   - Push on ic_rsp_valid_i.
//   - Space is guaranteed by meta occupancy, so it never overflows.
// - Cache returns responses in request order.
//   - ic_rsp_tag_i must equal the warp id of the oldest unanswered meta entry (assertion).
// - dec_valid_o = !instr_empty. Payload = instr FIFO head + meta FIFO head.
//   - Pop both on dec_valid_o && dec_ready_i.
//   - Payload is held stable while valid && !ready.
// - Latency: request handshake in cycle N, response in cycle M gives dec_valid_o in cycle M+1 (registered FIFO).
// - Full: meta_full forces ic_req_valid_o=0.
//   - A same-cycle decoder pop does NOT free the slot, so there is no combinational ready path.
// - Simultaneous push and pop on either FIFO in the same cycle is legal; occupancy is unchanged.
// - Empty: dec_valid_o=0, and dec_ready_i is ignored.
// - No ready warps: ic_req_valid_o=0 and the RR pointer is held.
// - Reset mid-operation: all in-flight entries are dropped.
//   - The environment resets the cache and the ITS units together with this block.
// - Assertions:
//   - no ic_rsp_valid_i with 0 outstanding;
//   - no push to a full FIFO;
//   - warp_selected_o is onehot0.
// STRUCTURE
// - bgpu_pkg: fetch_meta_t struct {pc_t, act_mask_t, warp_id_t, subwarp_id_t}, and the warp_id_t / subwarp_id_t typedefs.
// - Both FIFOs use common_cells fifo_v3 (FALL_THROUGH=0).
// - One natural sub-module: fetch_rr_picker.
//   - Priority pointer plus a one-hot first-set search over NumWarps.
//   - Outputs a winner index and a valid flag.
// - All remaining logic stays in this module.
// TESTING
// 1. Reset, then warp 2 ready (pc=0x100) with ic_req_ready_i=1.
//    -> ic_req_pc_o=0x100, tag=2, warp_selected_o=8'b0000_0100 for one cycle.
// 2. Warps 0, 1 and 3 ready continuously, cache always ready.
//    -> grants in order 0,1,3,0,1,3; the pointer wraps correctly.
// 3. Cache never responds, one warp always ready.
//    -> exactly 4 handshakes, then ic_req_valid_o=0 until responses arrive.
// 4. Two requests (pc 0x40 warp1, pc 0x80 warp5), responses 0xAAAA and 0xBBBB, dec_ready_i=0 for 5 cycles.
//    -> dec stays {0x40, 1, 0xAAAA} and stable; after ready, the next beat is {0x80, 5, 0xBBBB}.
// 5. Full FIFO with dec pop and a new request in the same cycle.
//    -> no issue that cycle; issue follows the next cycle.
// 6. rst_ni asserted with 3 entries in flight.
//    -> dec_valid_o=0, ic_req_valid_o=0, warp_selected_o=0 immediately (async).

Source files
------------

// File: rtl/bgpu_pkg.sv
// Shared types for the fetch/issue stage: warp/subwarp ids, PC and mask types,
// and the per-fetch metadata record carried alongside each in-flight request.
package bgpu_pkg;

  localparam int unsigned NumWarps       = 8;
  localparam int unsigned WarpWidth      = 32;
  localparam int unsigned PcWidth        = 32;
  localparam int unsigned InstrWidth     = 32;
  localparam int unsigned MaxOutstanding = 4;

  localparam int unsigned WarpIdWidth    = $clog2(NumWarps);
  localparam int unsigned SubwarpIdWidth = $clog2(WarpWidth);
  localparam int unsigned OutPtrWidth    = $clog2(MaxOutstanding);
  localparam int unsigned OccWidth       = $clog2(MaxOutstanding) + 1;

  typedef logic [PcWidth-1:0]        pc_t;
  typedef logic [WarpWidth-1:0]      act_mask_t;
  typedef logic [WarpIdWidth-1:0]    warp_id_t;
  typedef logic [SubwarpIdWidth-1:0] subwarp_id_t;
  typedef logic [InstrWidth-1:0]     instr_t;

  typedef struct packed {
    pc_t         pc;
    act_mask_t   act_mask;
    warp_id_t    warp_id;
    subwarp_id_t subwarp_id;
  } fetch_meta_t;

  function automatic warp_id_t next_warp(input warp_id_t w);
    if (w == warp_id_t'(NumWarps - 1)) return '0;
    return w + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_rr_picker.sv
// Round-robin picker: first ready warp at or after the priority pointer,
// wrapping; the pointer moves past the winner only when advance_i is high.
module fetch_rr_picker
  import bgpu_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumWarps-1:0] ready_i,
  input  logic                advance_i,
  output logic                valid_o,
  output warp_id_t            winner_o
);

  localparam logic [NumWarps-1:0] One = {{(NumWarps-1){1'b0}}, 1'b1};

  warp_id_t            ptr_q, ptr_d;
  logic [NumWarps-1:0] hi_mask, hi_req, hi_onehot, lo_onehot, sel_onehot;

  always_comb begin
    for (int i = 0; i < NumWarps; i++) begin
      hi_mask[i] = (i >= int'(ptr_q));
    end
    hi_req = ready_i & hi_mask;
    // x & -x isolates the lowest set bit.
    hi_onehot  = hi_req & (~hi_req + One);
    lo_onehot  = ready_i & (~ready_i + One);
    sel_onehot = (|hi_req) ? hi_onehot : lo_onehot;
    winner_o   = '0;
    for (int i = 0; i < NumWarps; i++) begin
      if (sel_onehot[i]) winner_o = winner_o | warp_id_t'(i);
    end
    valid_o = |ready_i;
    ptr_d   = (advance_i && valid_o) ? next_warp(winner_o) : ptr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fifo_v3.sv
// Small synchronous FIFO with the common_cells fifo_v3 port shape; registered
// output when FALL_THROUGH=0 (data pushed in cycle N is visible in N+1).
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DEPTH        = 4,
  parameter type         dtype        = logic [31:0]
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  output logic full_o,
  output logic empty_o,
  input  dtype data_i,
  input  logic push_i,
  output dtype data_o,
  input  logic pop_i
);

  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);

  dtype             mem_q [DEPTH];
  dtype             mem_d [DEPTH];
  logic [AddrW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  function automatic logic [AddrW-1:0] inc_ptr(input logic [AddrW-1:0] p);
    return (p == AddrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign empty_o = (cnt_q == '0);

  always_comb begin
    mem_d  = mem_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    data_o = mem_q[rd_q];
    if (push_i && !full_o) begin
      mem_d[wr_q] = data_i;
      wr_d        = inc_ptr(wr_q);
      cnt_d       = cnt_d + 1'b1;
    end
    if (pop_i && !empty_o) begin
      rd_d  = inc_ptr(rd_q);
      cnt_d = cnt_d - 1'b1;
    end
    // Bypass path: an empty FIFO can forward and consume in the same cycle.
    if (FALL_THROUGH && empty_o && push_i) begin
      data_o = data_i;
      if (pop_i) begin
        rd_d  = inc_ptr(rd_q);
        cnt_d = cnt_q;
      end
    end
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '{default: '0};
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fetch_issue_stage.sv
// Fetch/issue stage: arbitrates ready warps, issues PCs to the I-cache, and
// pairs in-order cache responses with their metadata for the decoder.
module fetch_issue_stage
  import bgpu_pkg::*;
(
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NumWarps-1:0]                warp_ready_i,
  input  logic [NumWarps*PcWidth-1:0]        warp_pc_i,
  input  logic [NumWarps*WarpWidth-1:0]      warp_act_mask_i,
  input  logic [NumWarps*SubwarpIdWidth-1:0] warp_subwarp_id_i,
  output logic [NumWarps-1:0]                warp_selected_o,
  output logic                               ic_req_valid_o,
  input  logic                               ic_req_ready_i,
  output logic [PcWidth-1:0]                 ic_req_pc_o,
  output logic [WarpIdWidth-1:0]             ic_req_tag_o,
  input  logic                               ic_rsp_valid_i,
  input  logic [WarpIdWidth-1:0]             ic_rsp_tag_i,
  input  logic [InstrWidth-1:0]              ic_rsp_instr_i,
  output logic                               dec_valid_o,
  input  logic                               dec_ready_i,
  output logic [PcWidth-1:0]                 dec_pc_o,
  output logic [WarpWidth-1:0]               dec_act_mask_o,
  output logic [WarpIdWidth-1:0]             dec_warp_id_o,
  output logic [SubwarpIdWidth-1:0]          dec_subwarp_id_o,
  output logic [InstrWidth-1:0]              dec_instr_o
);

  logic        pick_valid;
  warp_id_t    winner;
  logic        req_hs, dec_hs;
  logic        meta_full, meta_empty, instr_full, instr_empty;
  fetch_meta_t meta_in, meta_head;
  instr_t      instr_head;

  warp_id_t               tag_q [MaxOutstanding];
  warp_id_t               tag_d [MaxOutstanding];
  logic [OutPtrWidth-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [OccWidth-1:0]    outstanding_q, outstanding_d;

  fetch_rr_picker i_picker (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .ready_i   (warp_ready_i),
    .advance_i (req_hs),
    .valid_o   (pick_valid),
    .winner_o  (winner)
  );

  // Gated by rst_ni so nothing is offered to the cache while reset is held.
  assign ic_req_valid_o = rst_ni && pick_valid && !meta_full;
  assign req_hs         = ic_req_valid_o && ic_req_ready_i;
  assign ic_req_tag_o   = winner;
  assign ic_req_pc_o    = warp_pc_i[int'(winner)*PcWidth +: PcWidth];

  always_comb begin
    warp_selected_o = '0;
    if (req_hs) warp_selected_o[winner] = 1'b1;
  end

  always_comb begin
    meta_in.pc         = ic_req_pc_o;
    meta_in.act_mask   = warp_act_mask_i[int'(winner)*WarpWidth +: WarpWidth];
    meta_in.warp_id    = winner;
    meta_in.subwarp_id = warp_subwarp_id_i[int'(winner)*SubwarpIdWidth +: SubwarpIdWidth];
  end

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DEPTH        (MaxOutstanding),
    .dtype        (fetch_meta_t)
  ) i_meta_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (meta_full),
    .empty_o (meta_empty),
    .data_i  (meta_in),
    .push_i  (req_hs),
    .data_o  (meta_head),
    .pop_i   (dec_hs)
  );

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DEPTH        (MaxOutstanding),
    .dtype        (instr_t)
  ) i_instr_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (instr_full),
    .empty_o (instr_empty),
    .data_i  (ic_rsp_instr_i),
    .push_i  (ic_rsp_valid_i),
    .data_o  (instr_head),
    .pop_i   (dec_hs)
  );

  assign dec_valid_o      = !instr_empty;
  assign dec_hs           = dec_valid_o && dec_ready_i;
  assign dec_pc_o         = meta_head.pc;
  assign dec_act_mask_o   = meta_head.act_mask;
  assign dec_warp_id_o    = meta_head.warp_id;
  assign dec_subwarp_id_o = meta_head.subwarp_id;
  assign dec_instr_o      = instr_head;

  // Tags of requests the cache has not answered yet, oldest at tag_rd_q.
  always_comb begin
    tag_d         = tag_q;
    tag_wr_d      = tag_wr_q;
    tag_rd_d      = tag_rd_q;
    outstanding_d = outstanding_q;
    if (req_hs) begin
      tag_d[tag_wr_q] = winner;
      tag_wr_d        = tag_wr_q + 1'b1;
    end
    if (ic_rsp_valid_i) tag_rd_d = tag_rd_q + 1'b1;
    case ({req_hs, ic_rsp_valid_i})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_q         <= '{default: '0};
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
      outstanding_q <= '0;
    end else begin
      tag_q         <= tag_d;
      tag_wr_q      <= tag_wr_d;
      tag_rd_q      <= tag_rd_d;
      outstanding_q <= outstanding_d;
    end
  end

  a_rsp_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ic_rsp_valid_i |-> (outstanding_q != '0));
  a_rsp_in_order: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ic_rsp_valid_i |-> (ic_rsp_tag_i == tag_q[tag_rd_q]));
  a_meta_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(req_hs && meta_full));
  a_instr_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(ic_rsp_valid_i && instr_full));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    dec_hs |-> !meta_empty);
  a_sel_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(warp_selected_o));

endmodule

// File: tb/tb_fetch_issue_stage.sv
// Directed bench for fetch_issue_stage: arbitration, cache flow control,
// decoder backpressure and asynchronous reset.
module tb_fetch_issue_stage;
  import bgpu_pkg::*;

  logic                               clk_i = 1'b0;
  logic                               rst_ni;
  logic [NumWarps-1:0]                warp_ready_i;
  logic [NumWarps*PcWidth-1:0]        warp_pc_i;
  logic [NumWarps*WarpWidth-1:0]      warp_act_mask_i;
  logic [NumWarps*SubwarpIdWidth-1:0] warp_subwarp_id_i;
  logic [NumWarps-1:0]                warp_selected_o;
  logic                               ic_req_valid_o;
  logic                               ic_req_ready_i;
  logic [PcWidth-1:0]                 ic_req_pc_o;
  logic [WarpIdWidth-1:0]             ic_req_tag_o;
  logic                               ic_rsp_valid_i;
  logic [WarpIdWidth-1:0]             ic_rsp_tag_i;
  logic [InstrWidth-1:0]              ic_rsp_instr_i;
  logic                               dec_valid_o;
  logic                               dec_ready_i;
  logic [PcWidth-1:0]                 dec_pc_o;
  logic [WarpWidth-1:0]               dec_act_mask_o;
  logic [WarpIdWidth-1:0]             dec_warp_id_o;
  logic [SubwarpIdWidth-1:0]          dec_subwarp_id_o;
  logic [InstrWidth-1:0]              dec_instr_o;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_issue_stage dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .warp_ready_i      (warp_ready_i),
    .warp_pc_i         (warp_pc_i),
    .warp_act_mask_i   (warp_act_mask_i),
    .warp_subwarp_id_i (warp_subwarp_id_i),
    .warp_selected_o   (warp_selected_o),
    .ic_req_valid_o    (ic_req_valid_o),
    .ic_req_ready_i    (ic_req_ready_i),
    .ic_req_pc_o       (ic_req_pc_o),
    .ic_req_tag_o      (ic_req_tag_o),
    .ic_rsp_valid_i    (ic_rsp_valid_i),
    .ic_rsp_tag_i      (ic_rsp_tag_i),
    .ic_rsp_instr_i    (ic_rsp_instr_i),
    .dec_valid_o       (dec_valid_o),
    .dec_ready_i       (dec_ready_i),
    .dec_pc_o          (dec_pc_o),
    .dec_act_mask_o    (dec_act_mask_o),
    .dec_warp_id_o     (dec_warp_id_o),
    .dec_subwarp_id_o  (dec_subwarp_id_o),
    .dec_instr_o       (dec_instr_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change 1 time unit after a rising edge; checks happen mid-cycle.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    warp_ready_i      = '0;
    warp_pc_i         = '0;
    warp_act_mask_i   = '0;
    warp_subwarp_id_i = '0;
    ic_req_ready_i    = 1'b0;
    ic_rsp_valid_i    = 1'b0;
    ic_rsp_tag_i      = '0;
    ic_rsp_instr_i    = '0;
    dec_ready_i       = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic set_warp(input int w, input logic [31:0] pc, input logic [31:0] mask,
                          input logic [4:0] sub);
    warp_pc_i[w*PcWidth +: PcWidth]                        = pc;
    warp_act_mask_i[w*WarpWidth +: WarpWidth]              = mask;
    warp_subwarp_id_i[w*SubwarpIdWidth +: SubwarpIdWidth]  = sub;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    clear_inputs();
    warp_ready_i   = 8'hFF;
    ic_req_ready_i = 1'b1;
    #2;
    n_checks++; if (ic_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b expected 0", ic_req_valid_o); end
    n_checks++; if (warp_selected_o !== 8'h00) begin n_fail++; $display("FAIL rst_sel: got %h expected 00", warp_selected_o); end
    n_checks++; if (dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_dec_valid: got %b expected 0", dec_valid_o); end
    @(posedge clk_i);
    #1;
    rst_ni       = 1'b1;
    warp_ready_i = '0;
    #2;
    n_checks++; if (ic_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_idle_valid: got %b expected 0", ic_req_valid_o); end
    n_checks++; if (dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_idle_dec: got %b expected 0", dec_valid_o); end
  endtask

  task automatic test_single_grant();
    do_reset();
    set_warp(2, 32'h100, 32'hFFFF_FFFF, 5'd0);
    warp_ready_i = 8'b0000_0100;
    #2;
    n_checks++; if (ic_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL t1_valid_noready: got %b expected 1", ic_req_valid_o); end
    n_checks++; if (warp_selected_o !== 8'h00) begin n_fail++; $display("FAIL t1_sel_nohs: got %h expected 00", warp_selected_o); end
    ic_req_ready_i = 1'b1;
    #1;
    n_checks++; if (ic_req_pc_o !== 32'h100) begin n_fail++; $display("FAIL t1_pc: got %h expected 00000100", ic_req_pc_o); end
    n_checks++; if (ic_req_tag_o !== 3'd2) begin n_fail++; $display("FAIL t1_tag: got %0d expected 2", ic_req_tag_o); end
    n_checks++; if (warp_selected_o !== 8'b0000_0100) begin n_fail++; $display("FAIL t1_sel: got %b expected 00000100", warp_selected_o); end
    step();
    warp_ready_i = '0;
    #2;
    n_checks++; if (warp_selected_o !== 8'h00) begin n_fail++; $display("FAIL t1_sel_after: got %h expected 00", warp_selected_o); end
    n_checks++; if (ic_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL t1_valid_after: got %b expected 0", ic_req_valid_o); end
  endtask

  task automatic test_rr_wrap();
    int seq [6] = '{0, 1, 3, 0, 1, 3};
    logic [7:0]  exp_sel;
    logic [31:0] exp_pc;
    do_reset();
    for (int w = 0; w < NumWarps; w++) set_warp(w, 32'h1000 + 32'(w * 4), 32'h0000_0001 << w, 5'(w));
    warp_ready_i   = 8'b0000_1011;
    ic_req_ready_i = 1'b1;
    dec_ready_i    = 1'b1;
    for (int k = 0; k < 6; k++) begin
      ic_rsp_valid_i = (k > 0);
      ic_rsp_tag_i   = (k > 0) ? 3'(seq[k-1]) : 3'd0;
      ic_rsp_instr_i = 32'hC000 + 32'(k - 1);
      #2;
      exp_sel = 8'h01 << seq[k];
      n_checks++; if (warp_selected_o !== exp_sel) begin n_fail++; $display("FAIL rr_sel k=%0d: got %b expected %b", k, warp_selected_o, exp_sel); end
      if (k >= 2) begin
        exp_pc = 32'h1000 + 32'(seq[k-2] * 4);
        n_checks++; if (dec_valid_o !== 1'b1 || dec_warp_id_o !== 3'(seq[k-2]) || dec_pc_o !== exp_pc || dec_instr_o !== 32'hC000 + 32'(k - 2))
          begin n_fail++; $display("FAIL rr_dec k=%0d: got v=%b w=%0d pc=%h i=%h expected v=1 w=%0d pc=%h i=%h", k, dec_valid_o, dec_warp_id_o, dec_pc_o, dec_instr_o, seq[k-2], exp_pc, 32'hC000 + 32'(k - 2)); end
      end
      step();
    end
    warp_ready_i   = '0;
    ic_rsp_valid_i = 1'b0;
  endtask

  task automatic test_full_stall();
    int hs = 0;
    do_reset();
    set_warp(4, 32'h400, 32'hFFFF_0000, 5'd1);
    warp_ready_i   = 8'h10;
    ic_req_ready_i = 1'b1;
    dec_ready_i    = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #2;
      if (ic_req_valid_o && ic_req_ready_i) hs++;
      step();
    end
    #2;
    n_checks++; if (hs != 4) begin n_fail++; $display("FAIL full_hs_count: got %0d expected 4", hs); end
    n_checks++; if (ic_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL full_valid: got %b expected 0", ic_req_valid_o); end
    n_checks++; if (dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL full_dec: got %b expected 0", dec_valid_o); end
  endtask

  task automatic test_full_pop_same_cycle();
    do_reset();
    set_warp(4, 32'h400, 32'hFFFF_0000, 5'd1);
    warp_ready_i   = 8'h10;
    ic_req_ready_i = 1'b1;
    dec_ready_i    = 1'b1;
    repeat (4) step();
    ic_rsp_valid_i = 1'b1;
    ic_rsp_tag_i   = 3'd4;
    ic_rsp_instr_i = 32'hD00D;
    #2;
    n_checks++; if (ic_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL pop_full_valid: got %b expected 0", ic_req_valid_o); end
    step();
    ic_rsp_valid_i = 1'b0;
    #2;
    n_checks++; if (dec_valid_o !== 1'b1 || dec_instr_o !== 32'hD00D) begin n_fail++; $display("FAIL pop_dec: got v=%b i=%h expected v=1 i=0000d00d", dec_valid_o, dec_instr_o); end
    n_checks++; if (ic_req_valid_o !== 1'b0 || warp_selected_o !== 8'h00) begin n_fail++; $display("FAIL pop_same_cycle_issue: got v=%b sel=%h expected v=0 sel=00", ic_req_valid_o, warp_selected_o); end
    step();
    #2;
    n_checks++; if (ic_req_valid_o !== 1'b1 || warp_selected_o !== 8'h10) begin n_fail++; $display("FAIL pop_next_issue: got v=%b sel=%h expected v=1 sel=10", ic_req_valid_o, warp_selected_o); end
    warp_ready_i = '0;
  endtask

  task automatic test_dec_backpressure();
    do_reset();
    set_warp(1, 32'h40, 32'hF0F0_0001, 5'd3);
    set_warp(5, 32'h80, 32'h0000_FFFF, 5'd7);
    ic_req_ready_i = 1'b1;
    warp_ready_i   = 8'h02;
    #2;
    n_checks++; if (ic_req_tag_o !== 3'd1 || ic_req_pc_o !== 32'h40) begin n_fail++; $display("FAIL bp_req0: got tag=%0d pc=%h expected tag=1 pc=00000040", ic_req_tag_o, ic_req_pc_o); end
    step();
    warp_ready_i = 8'h20;
    #2;
    n_checks++; if (ic_req_tag_o !== 3'd5 || ic_req_pc_o !== 32'h80) begin n_fail++; $display("FAIL bp_req1: got tag=%0d pc=%h expected tag=5 pc=00000080", ic_req_tag_o, ic_req_pc_o); end
    step();
    warp_ready_i   = '0;
    ic_rsp_valid_i = 1'b1;
    ic_rsp_tag_i   = 3'd1;
    ic_rsp_instr_i = 32'hAAAA;
    #2;
    n_checks++; if (dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_latency: got %b expected 0", dec_valid_o); end
    step();
    ic_rsp_tag_i   = 3'd5;
    ic_rsp_instr_i = 32'hBBBB;
    for (int c = 0; c < 5; c++) begin
      #2;
      n_checks++; if (dec_valid_o !== 1'b1 || dec_pc_o !== 32'h40 || dec_warp_id_o !== 3'd1 || dec_instr_o !== 32'hAAAA)
        begin n_fail++; $display("FAIL bp_hold c=%0d: got v=%b pc=%h w=%0d i=%h expected v=1 pc=00000040 w=1 i=0000aaaa", c, dec_valid_o, dec_pc_o, dec_warp_id_o, dec_instr_o); end
      step();
      ic_rsp_valid_i = 1'b0;
    end
    dec_ready_i = 1'b1;
    #2;
    n_checks++; if (dec_act_mask_o !== 32'hF0F0_0001 || dec_subwarp_id_o !== 5'd3 || dec_instr_o !== 32'hAAAA)
      begin n_fail++; $display("FAIL bp_first: got m=%h s=%0d i=%h expected m=f0f00001 s=3 i=0000aaaa", dec_act_mask_o, dec_subwarp_id_o, dec_instr_o); end
    step();
    dec_ready_i = 1'b0;
    #2;
    n_checks++; if (dec_valid_o !== 1'b1 || dec_pc_o !== 32'h80 || dec_warp_id_o !== 3'd5 || dec_instr_o !== 32'hBBBB || dec_act_mask_o !== 32'h0000_FFFF || dec_subwarp_id_o !== 5'd7)
      begin n_fail++; $display("FAIL bp_second: got v=%b pc=%h w=%0d i=%h m=%h s=%0d expected v=1 pc=00000080 w=5 i=0000bbbb m=0000ffff s=7", dec_valid_o, dec_pc_o, dec_warp_id_o, dec_instr_o, dec_act_mask_o, dec_subwarp_id_o); end
    dec_ready_i = 1'b1;
    step();
    #2;
    n_checks++; if (dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b expected 0", dec_valid_o); end
    step();
    #2;
    n_checks++; if (dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_empty_ready: got %b expected 0", dec_valid_o); end
    dec_ready_i = 1'b0;
  endtask

  task automatic test_idle_hold();
    do_reset();
    set_warp(0, 32'h200, 32'h1, 5'd0);
    set_warp(1, 32'h210, 32'h1, 5'd0);
    set_warp(3, 32'h230, 32'h1, 5'd0);
    ic_req_ready_i = 1'b1;
    warp_ready_i   = 8'h02;
    step();
    warp_ready_i = '0;
    #2;
    n_checks++; if (ic_req_valid_o !== 1'b0 || warp_selected_o !== 8'h00) begin n_fail++; $display("FAIL idle_valid: got v=%b sel=%h expected v=0 sel=00", ic_req_valid_o, warp_selected_o); end
    repeat (3) step();
    warp_ready_i = 8'b0000_1001;
    #2;
    n_checks++; if (ic_req_tag_o !== 3'd3 || ic_req_pc_o !== 32'h230 || warp_selected_o !== 8'h08)
      begin n_fail++; $display("FAIL idle_ptr_held: got tag=%0d pc=%h sel=%h expected tag=3 pc=00000230 sel=08", ic_req_tag_o, ic_req_pc_o, warp_selected_o); end
    warp_ready_i = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int w = 0; w < 3; w++) set_warp(w, 32'h300 + 32'(w * 4), 32'hFFFF_FFFF, 5'(w));
    warp_ready_i   = 8'h07;
    ic_req_ready_i = 1'b1;
    step();
    ic_rsp_valid_i = 1'b1;
    ic_rsp_tag_i   = 3'd0;
    ic_rsp_instr_i = 32'hE000;
    step();
    ic_rsp_tag_i   = 3'd1;
    ic_rsp_instr_i = 32'hE001;
    step();
    ic_rsp_valid_i = 1'b0;
    warp_ready_i   = '0;
    #2;
    n_checks++; if (dec_valid_o !== 1'b1 || dec_instr_o !== 32'hE000) begin n_fail++; $display("FAIL mid_pre_dec: got v=%b i=%h expected v=1 i=0000e000", dec_valid_o, dec_instr_o); end
    warp_ready_i = 8'h07;
    #1;
    n_checks++; if (ic_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b expected 1", ic_req_valid_o); end
    rst_ni = 1'b0;
    #1;
    n_checks++; if (dec_valid_o !== 1'b0 || ic_req_valid_o !== 1'b0 || warp_selected_o !== 8'h00)
      begin n_fail++; $display("FAIL mid_async: got dec=%b req=%b sel=%h expected dec=0 req=0 sel=00", dec_valid_o, ic_req_valid_o, warp_selected_o); end
    step();
    rst_ni       = 1'b1;
    warp_ready_i = '0;
    #2;
    n_checks++; if (dec_valid_o !== 1'b0 || ic_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_dropped: got dec=%b req=%b expected dec=0 req=0", dec_valid_o, ic_req_valid_o); end
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_rr_wrap();
    test_full_stall();
    test_full_pop_same_cycle();
    test_dec_backpressure();
    test_idle_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
